// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI port between two debug requesters; one whole transaction at a time.
// Latency: grant -> dmi_req_valid_o +1 cycle; DM response -> resp_valid_o +1 cycle; aborts with resp 2 on a DM stall.
module dmi_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]              req_op_i,
  input  logic [63:0]             req_data_i,
  output logic [1:0]              resp_valid_o,
  input  logic [1:0]              resp_ready_i,
  output logic [31:0]             resp_data_o,
  output logic [1:0]              resp_resp_o,
  output logic                    dmi_req_valid_o,
  input  logic                    dmi_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   dmi_req_addr_o,
  output logic [1:0]              dmi_req_op_o,
  output logic [31:0]             dmi_req_data_o,
  input  logic                    dmi_resp_valid_i,
  output logic                    dmi_resp_ready_o,
  input  logic [31:0]             dmi_resp_data_i,
  input  logic [1:0]              dmi_resp_resp_i,
  output logic                    owner_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_q;
  logic             stale_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant;
  logic             rsp_accept;
  logic             to_fire;
  logic             stale_drop;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 2'b00;
    grant       = (&req_valid_i) ? ~last_q : req_valid_i[1];
    rsp_accept  = (state_q == WAIT) && dmi_resp_valid_i && !stale_q;
    // a beat landing in the timeout cycle wins over the abort
    to_fire     = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && (cnt_q == CNT_LAST) && !rsp_accept;
    stale_drop  = dmi_resp_valid_i && stale_q;
    case (state_q)
      IDLE: if (|req_valid_i) begin
        req_ready_o[grant] = 1'b1;
        state_d            = REQ;
      end
      REQ:  if (dmi_req_ready_i) state_d = WAIT;
      WAIT: if (rsp_accept || to_fire) state_d = RESP;
      RESP: if (resp_ready_i[owner_o]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      stale_q        <= 1'b0;
      cnt_q          <= '0;
      owner_o        <= 1'b0;
      timeout_o      <= 1'b0;
      dmi_req_addr_o <= '0;
      dmi_req_op_o   <= 2'd0;
      dmi_req_data_o <= 32'd0;
      resp_data_o    <= 32'd0;
      resp_resp_o    <= 2'd0;
    end else begin
      state_q   <= state_d;
      timeout_o <= to_fire;
      if (state_q == IDLE && |req_valid_i) begin
        owner_o        <= grant;
        dmi_req_addr_o <= grant ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
        dmi_req_op_o   <= grant ? req_op_i[3:2] : req_op_i[1:0];
        dmi_req_data_o <= grant ? req_data_i[63:32] : req_data_i[31:0];
      end
      if (state_q == REQ && dmi_req_ready_i) cnt_q <= '0;
      else if (state_q == WAIT)              cnt_q <= cnt_q + 1'b1;
      if (rsp_accept) begin
        resp_data_o <= dmi_resp_data_i;
        resp_resp_o <= dmi_resp_resp_i;
      end else if (to_fire) begin
        resp_data_o <= 32'd0;
        resp_resp_o <= 2'd2;
      end
      // the aborted request's response is still in flight; swallow it when it shows up
      if (to_fire)         stale_q <= 1'b1;
      else if (stale_drop) stale_q <= 1'b0;
      if (state_q == RESP && resp_ready_i[owner_o]) last_q <= owner_o;
    end
  end

  assign dmi_req_valid_o  = (state_q == REQ);
  assign dmi_resp_ready_o = (state_q == WAIT) || stale_q;
  assign busy_o           = (state_q != IDLE);
  assign resp_valid_o     = (state_q == RESP) ? (owner_o ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: vector table of full transactions plus stall, timeout, stale and reset sequences.
module tb_dmi_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [13:0] req_addr = '0;
  logic [3:0]  req_op = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  logic [6:0]  dmi_req_addr;
  logic [1:0]  dmi_req_op;
  logic [31:0] dmi_req_data;
  logic        dmi_resp_valid = 1'b0;
  logic        dmi_resp_ready;
  logic [31:0] dmi_resp_data = '0;
  logic [1:0]  dmi_resp_resp = '0;
  logic        owner, busy, timeout;

  int    n_chk = 0;
  int    n_fail = 0;
  string tag = "";

  always #5 clk = ~clk;

  dmi_arbiter #(.ADDR_WIDTH(7), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_op_i(req_op), .req_data_i(req_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_resp_o(resp_resp),
    .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
    .dmi_req_addr_o(dmi_req_addr), .dmi_req_op_o(dmi_req_op), .dmi_req_data_o(dmi_req_data),
    .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
    .dmi_resp_data_i(dmi_resp_data), .dmi_resp_resp_i(dmi_resp_resp),
    .owner_o(owner), .busy_o(busy), .timeout_o(timeout)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [6:0]  a0;
    logic [1:0]  op0;
    logic [31:0] d0;
    logic [6:0]  a1;
    logic [1:0]  op1;
    logic [31:0] d1;
    int          delay;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        exp_own;
    logic [6:0]  ea;
    logic [1:0]  eop;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  // Caller is at posedge+1 in IDLE; returns at posedge+1 right after the response handshake.
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = v.exp_own ? 2'b10 : 2'b01;
    if (v.rst) pulse_reset();
    req_valid = v.vld;
    req_addr  = {v.a1, v.a0};
    req_op    = {v.op1, v.op0};
    req_data  = {v.d1, v.d0};
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("grant", req_ready, oh);
    step();
    req_valid     = v.vld & ~oh;
    dmi_req_ready = 1'b1;
    @(negedge clk);
    chk("dmi_vld", dmi_req_valid, 1);
    chk("addr", dmi_req_addr, v.ea);
    chk("op", dmi_req_op, v.eop);
    chk("wdata", dmi_req_data, v.ed);
    chk("owner", owner, v.exp_own);
    chk("rdy_busy", req_ready, 0);
    step();
    dmi_req_ready = 1'b0;
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      chk("wait_rvld", resp_valid, 0);
      chk("wait_dmi_rdy", dmi_resp_ready, 1);
      step();
    end
    dmi_resp_valid = 1'b1;
    dmi_resp_data  = v.rdata;
    dmi_resp_resp  = v.rresp;
    step();
    dmi_resp_valid = 1'b0;
    resp_ready     = oh;
    @(negedge clk);
    chk("rvld", resp_valid, oh);
    chk("rdata", resp_data, v.rdata);
    chk("rresp", resp_resp, v.rresp);
    chk("rtimeout", timeout, 0);
    chk("resp_dmi_vld", dmi_req_valid, 0);
    step();
    resp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst  vld    a0     op0  d0            a1     op1  d1            dly rdata          rr    own   ea     eop  ed
    vecs[0] = '{1'b0, 2'b01, 7'h11, 2'd1, 32'h0,        7'h00, 2'd0, 32'h0,        1, 32'h00000C82, 2'd0, 1'b0, 7'h11, 2'd1, 32'h0};
    vecs[1] = '{1'b1, 2'b11, 7'h21, 2'd1, 32'h0,        7'h31, 2'd2, 32'h11111111, 0, 32'hA0000000, 2'd0, 1'b0, 7'h21, 2'd1, 32'h0};
    vecs[2] = '{1'b0, 2'b11, 7'h22, 2'd1, 32'h0,        7'h31, 2'd2, 32'h11111111, 2, 32'hA0000001, 2'd0, 1'b1, 7'h31, 2'd2, 32'h11111111};
    vecs[3] = '{1'b0, 2'b11, 7'h23, 2'd2, 32'h22222222, 7'h32, 2'd1, 32'h0,        1, 32'hA0000002, 2'd0, 1'b0, 7'h23, 2'd2, 32'h22222222};
    vecs[4] = '{1'b0, 2'b11, 7'h24, 2'd1, 32'h0,        7'h33, 2'd1, 32'h0,        0, 32'hA0000003, 2'd0, 1'b1, 7'h33, 2'd1, 32'h0};
    vecs[5] = '{1'b0, 2'b10, 7'h00, 2'd0, 32'h0,        7'h34, 2'd2, 32'h5A5A5A5A, 1, 32'h0000BEEF, 2'd0, 1'b1, 7'h34, 2'd2, 32'h5A5A5A5A};
    vecs[6] = '{1'b0, 2'b01, 7'h10, 2'd2, 32'h80000001, 7'h00, 2'd0, 32'h0,        0, 32'h00000000, 2'd3, 1'b0, 7'h10, 2'd2, 32'h80000001};
    vecs[7] = '{1'b0, 2'b10, 7'h00, 2'd0, 32'h0,        7'h7F, 2'd0, 32'h0,        3, 32'h00000042, 2'd0, 1'b1, 7'h7F, 2'd0, 32'h0};

    tag = "reset";
    #2;
    chk("busy", busy, 0);
    chk("owner", owner, 0);
    chk("dmi_vld", dmi_req_valid, 0);
    chk("dmi_rdy", dmi_resp_ready, 0);
    chk("rvld", resp_valid, 0);
    chk("timeout", timeout, 0);
    chk("rdy", req_ready, 0);
    step();
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end
    req_valid = 2'b00;

    tag = "stall";
    req_valid = 2'b01; req_addr = {7'h00, 7'h16}; req_op = 4'b0010; req_data = {32'h0, 32'hCAFEF00D};
    @(negedge clk);
    chk("grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("vld", dmi_req_valid, 1);
      chk("addr", dmi_req_addr, 7'h16);
      chk("data", dmi_req_data, 32'hCAFEF00D);
      chk("op", dmi_req_op, 2'd2);
      chk("timeout", timeout, 0);
      step();
    end
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    step();
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'hA5A50001; dmi_resp_resp = 2'd0;
    step();
    dmi_resp_valid = 1'b0;
    resp_ready = 2'b01;
    @(negedge clk);
    chk("rvld", resp_valid, 2'b01);
    chk("rdata", resp_data, 32'hA5A50001);
    chk("rresp", resp_resp, 0);
    step();
    resp_ready = 2'b00;

    tag = "timeout";
    req_valid = 2'b01; req_addr = {7'h00, 7'h20}; req_op = 4'b0001;
    @(negedge clk);
    chk("grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00; dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("wait_rvld", resp_valid, 0);
      chk("wait_to", timeout, 0);
      step();
    end
    @(negedge clk);
    chk("rvld", resp_valid, 2'b01);
    chk("rresp", resp_resp, 2);
    chk("rdata", resp_data, 0);
    chk("pulse", timeout, 1);
    chk("stale_rdy", dmi_resp_ready, 1);
    step();
    @(negedge clk);
    chk("pulse_end", timeout, 0);
    chk("rvld_hold", resp_valid, 2'b01);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    @(negedge clk);
    chk("busy", busy, 0);
    chk("idle_stale_rdy", dmi_resp_ready, 1);
    step();

    tag = "stale";
    req_valid = 2'b10; req_addr = {7'h04, 7'h00}; req_op = 4'b0100;
    @(negedge clk);
    chk("grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00; dmi_req_ready = 1'b1;
    @(negedge clk);
    chk("addr", dmi_req_addr, 7'h04);
    chk("owner", owner, 1);
    step();
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'hDEAD0000; dmi_resp_resp = 2'd0;
    step();
    dmi_resp_data = 32'h12345678;
    @(negedge clk);
    chk("discard_rvld", resp_valid, 0);
    chk("discard_busy", busy, 1);
    step();
    dmi_resp_valid = 1'b0;
    resp_ready = 2'b10;
    @(negedge clk);
    chk("rvld", resp_valid, 2'b10);
    chk("rdata", resp_data, 32'h12345678);
    chk("rresp", resp_resp, 0);
    step();
    resp_ready = 2'b00;
    @(negedge clk);
    chk("dmi_rdy_clear", dmi_resp_ready, 0);
    step();

    tag = "rst_prep";
    run_vec('{1'b0, 2'b01, 7'h05, 2'd1, 32'h0, 7'h00, 2'd0, 32'h0, 0, 32'h0000F00D, 2'd0, 1'b0, 7'h05, 2'd1, 32'h0});
    tag = "rst_mid";
    req_valid = 2'b10; req_addr = {7'h06, 7'h00}; req_op = 4'b0100;
    step();
    req_valid = 2'b00; dmi_req_ready = 1'b1;
    @(negedge clk);
    chk("owner_pre", owner, 1);
    step();
    dmi_req_ready = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    chk("busy", busy, 0);
    chk("owner", owner, 0);
    chk("dmi_vld", dmi_req_valid, 0);
    chk("dmi_rdy", dmi_resp_ready, 0);
    chk("dmi_addr", dmi_req_addr, 0);
    chk("rvld", resp_valid, 0);
    chk("rdata", resp_data, 0);
    chk("timeout", timeout, 0);
    step();
    rst_ni = 1'b1;
    req_valid = 2'b11; req_addr = {7'h07, 7'h08}; req_op = 4'b0101;
    @(negedge clk);
    chk("tie_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00; dmi_req_ready = 1'b1;
    @(negedge clk);
    chk("tie_owner", owner, 0);
    chk("tie_addr", dmi_req_addr, 7'h08);
    step();
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h1; dmi_resp_resp = 2'd0;
    step();
    dmi_resp_valid = 1'b0;
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
